// File: rtl/fast_iter_sequencer.sv
// Run sequencer for the one-unit iteration controller: gates the unit with go_fast,
// normalises after each iteration and checks convergence, with rise/run watchdogs.
module fast_iter_sequencer #(
  parameter logic [7:0] MAX_ITER = 8'd100,
  parameter logic [7:0] WAIT_MAX = 8'd16,
  parameter logic [8:0] RUN_MAX  = 9'd300
) (
  input  logic       clk_fast,
  input  logic       rst,
  input  logic       start,
  input  logic       fast_busy,
  input  logic       converged,
  output logic       go_fast,
  output logic       norm_en,
  output logic       seq_busy,
  output logic       done,
  output logic       conv_ok,
  output logic       timeout_err,
  output logic [7:0] iter_cnt,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_BUSY = 3'd1,
    S_RUN       = 3'd2,
    S_NORM      = 3'd3,
    S_CHECK     = 3'd4,
    S_DONE      = 3'd5,
    S_ERR       = 3'd6
  } state_e;

  localparam logic [8:0] WAIT_LAST = {1'b0, WAIT_MAX} - 9'd1;
  localparam logic [8:0] RUN_LAST  = RUN_MAX - 9'd1;

  state_e     state_q, state_d;
  logic [8:0] wd_q, wd_d;
  logic [7:0] iter_q, iter_d;
  logic       conv_q, conv_d;
  logic       to_q, to_d;

  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wd_q    <= 9'd0;
      iter_q  <= 8'd0;
      conv_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      iter_q  <= iter_d;
      conv_q  <= conv_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    iter_d  = iter_q;
    conv_d  = conv_q;
    to_d    = to_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WAIT_BUSY;
          wd_d    = 9'd0;
          iter_d  = 8'd0;
          conv_d  = 1'b0;
          to_d    = 1'b0;
        end
      end
      S_WAIT_BUSY: begin
        // The unit responding on the last allowed cycle beats the timeout.
        wd_d = wd_q + 9'd1;
        if (fast_busy) begin
          state_d = S_RUN;
          wd_d    = 9'd0;
        end else if (wd_q == WAIT_LAST) begin
          state_d = S_ERR;
          to_d    = 1'b1;
        end
      end
      S_RUN: begin
        wd_d = wd_q + 9'd1;
        if (!fast_busy) begin
          state_d = S_NORM;
          wd_d    = 9'd0;
        end else if (wd_q == RUN_LAST) begin
          state_d = S_ERR;
          to_d    = 1'b1;
        end
      end
      S_NORM: begin
        state_d = S_CHECK;
        iter_d  = iter_q + 8'd1;
      end
      S_CHECK: begin
        if (converged) begin
          state_d = S_DONE;
          conv_d  = 1'b1;
        end else if (iter_q == MAX_ITER) begin
          state_d = S_DONE;
          conv_d  = 1'b0;
        end else begin
          state_d = S_WAIT_BUSY;
          wd_d    = 9'd0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NORM and CHECK keep go_fast low, so the unit sits in INIT for two cycles per iteration.
  assign go_fast     = (state_q == S_WAIT_BUSY) || (state_q == S_RUN);
  assign norm_en     = (state_q == S_NORM);
  assign seq_busy    = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE) || (state_q == S_ERR);
  assign conv_ok     = conv_q;
  assign timeout_err = to_q;
  assign iter_cnt    = iter_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_fast_iter_sequencer.sv
// Bench for fast_iter_sequencer: a behavioural one-unit model answers go_fast,
// and a scoreboard checks each run's result, length and pulse counts.
module tb_fast_iter_sequencer;

  logic       clk_fast = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       fast_busy = 1'b0;
  logic       converged = 1'b0;
  logic       go_fast, norm_en, seq_busy, done, conv_ok, timeout_err;
  logic [7:0] iter_cnt;
  logic [2:0] state_dbg;

  fast_iter_sequencer #(.MAX_ITER(8'd3), .WAIT_MAX(8'd16), .RUN_MAX(9'd300)) dut (
    .clk_fast(clk_fast), .rst(rst), .start(start), .fast_busy(fast_busy),
    .converged(converged), .go_fast(go_fast), .norm_en(norm_en), .seq_busy(seq_busy),
    .done(done), .conv_ok(conv_ok), .timeout_err(timeout_err), .iter_cnt(iter_cnt),
    .state_dbg(state_dbg)
  );

  always #5 clk_fast = ~clk_fast;

  // Result word is {timeout_err, conv_ok, iter_cnt}.
  typedef struct {
    int         k;
    int         b;
    int         b2;
    int         conv_at;
    int         exp_cyc;
    int         exp_go;
    int         exp_norm;
    logic [9:0] exp_res;
  } vec_t;

  vec_t       vecs[8];
  logic [9:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;

  int   cur_k, cur_b, cur_b2, cur_conv_at;
  int   busy_cnt;
  logic prev_go;
  int   n_go, n_norm, n_done, n_busy_cyc;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic reset_counters();
    n_go = 0; n_norm = 0; n_done = 0; n_busy_cyc = 0;
    prev_go = 1'b0; busy_cnt = 0;
  endtask

  // Called just after a falling edge: observe outputs, then drive the unit model.
  task automatic tick();
    int bl;
    if (go_fast && !prev_go) begin
      n_go++;
      busy_cnt = 0;
    end
    if (norm_en)  n_norm++;
    if (done)     n_done++;
    if (seq_busy) n_busy_cyc++;
    prev_go = go_fast;
    if (go_fast) begin
      bl = (n_go <= 1) ? cur_b : cur_b2;
      fast_busy = (busy_cnt >= cur_k) && (busy_cnt < cur_k + bl);
      busy_cnt++;
    end else begin
      fast_busy = 1'b0;
      busy_cnt = 0;
    end
    converged = (cur_conv_at != 0) && (n_norm >= cur_conv_at);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_fast);
    end
  endtask

  task automatic set_model(input int k, input int b, input int b2, input int conv_at);
    cur_k = k; cur_b = b; cur_b2 = b2; cur_conv_at = conv_at;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    bit         ok;
    logic [9:0] exp;
    set_model(v.k, v.b, v.b2, v.conv_at);
    reset_counters();
    @(negedge clk_fast);
    start = 1'b1;
    tick();
    @(negedge clk_fast);
    start = 1'b0;
    exp_q.push_back(v.exp_res);
    wait_done(1000, ok);
    check({tag, "_done_seen"}, 32'(ok), 32'd1);
    @(negedge clk_fast);
    tick();
    exp = exp_q.pop_front();
    check({tag, "_result"}, {22'd0, timeout_err, conv_ok, iter_cnt}, {22'd0, exp});
    check({tag, "_cycles"}, n_busy_cyc, v.exp_cyc);
    check({tag, "_go_windows"}, n_go, v.exp_go);
    check({tag, "_norm_pulses"}, n_norm, v.exp_norm);
    check({tag, "_done_pulses"}, n_done, 1);
    check({tag, "_idle_outs"}, {29'd0, go_fast, norm_en, seq_busy}, 32'd0);
  endtask

  initial begin
    bit   ok;
    vec_t rv;
    int   iters;

    //          k    b    b2  conv cyc  go nrm res
    vecs[0] = '{2,   128, 128, 1,  134, 1, 1, 10'h101};  // single convergence
    vecs[1] = '{1,   3,   3,   0,  22,  3, 3, 10'h003};  // MAX_ITER reached
    vecs[2] = '{0,   1,   1,   2,  9,   2, 2, 10'h102};  // immediate busy, 2 iterations
    vecs[3] = '{15,  5,   5,   1,  24,  1, 1, 10'h101};  // busy on watchdog count 15
    vecs[4] = '{3,   300, 300, 1,  307, 1, 1, 10'h101};  // busy falls on run count 299
    vecs[5] = '{16,  5,   5,   1,  17,  1, 0, 10'h200};  // rise timeout
    vecs[6] = '{4,   3,   400, 0,  316, 2, 1, 10'h201};  // run timeout in iteration 2
    vecs[7] = '{2,   2,   2,   3,  22,  3, 3, 10'h103};  // converge on last iteration
    set_model(0, 0, 0, 0);
    reset_counters();

    // Reset state, observed while rst is still high
    #12;
    check("reset_outs", {23'd0, go_fast, norm_en, seq_busy, done, conv_ok, timeout_err, state_dbg},
          32'd0);
    check("reset_iter", iter_cnt, 8'd0);
    @(negedge clk_fast);
    rst = 1'b0;
    repeat (2) @(negedge clk_fast);
    check("idle_no_start", seq_busy, 1'b0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Random runs; expected length follows n*(k+b+3)+1
    for (int r = 0; r < 4; r++) begin
      rv.k = $urandom_range(0, 10);
      rv.b = $urandom_range(1, 20);
      rv.b2 = rv.b;
      rv.conv_at = $urandom_range(0, 3);
      iters = (rv.conv_at == 0) ? 3 : rv.conv_at;
      rv.exp_cyc = iters * (rv.k + rv.b + 3) + 1;
      rv.exp_go = iters;
      rv.exp_norm = iters;
      rv.exp_res = {1'b0, (rv.conv_at != 0), 8'(iters)};
      run_vec(rv, $sformatf("rand%0d", r));
    end

    // start held high through DONE restarts on the first IDLE cycle
    set_model(0, 1, 1, 1);
    reset_counters();
    @(negedge clk_fast);
    start = 1'b1;
    tick();
    @(negedge clk_fast);
    wait_done(100, ok);
    check("held_first_done", 32'(ok), 32'd1);
    @(negedge clk_fast);
    tick();
    check("held_idle", {29'd0, seq_busy, conv_ok, 1'b0}, 32'd2);
    reset_counters();
    @(negedge clk_fast);
    tick();
    start = 1'b0;
    check("held_restart", {21'd0, seq_busy, go_fast, conv_ok, iter_cnt}, {21'd0, 3'b110, 8'd0});
    @(negedge clk_fast);
    wait_done(100, ok);
    check("held_second_done", 32'(ok), 32'd1);
    check("held_second_cycles", n_busy_cyc, 5);
    @(negedge clk_fast);
    tick();
    check("held_second_result", {22'd0, timeout_err, conv_ok, iter_cnt}, 32'h101);

    // Reset during RUN of iteration 2 aborts with no done
    set_model(2, 20, 20, 0);
    reset_counters();
    @(negedge clk_fast);
    start = 1'b1;
    tick();
    @(negedge clk_fast);
    start = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 500; c++) begin
      tick();
      if (n_go == 2 && state_dbg == 3'd2) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_fast);
    end
    check("abort_reached_run2", 32'(ok), 32'd1);
    check("abort_iter_before", iter_cnt, 8'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_async_outs", {23'd0, go_fast, norm_en, seq_busy, done, conv_ok, timeout_err, state_dbg},
          32'd0);
    check("abort_async_iter", iter_cnt, 8'd0);
    @(negedge clk_fast);
    rst = 1'b0;
    set_model(0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      @(negedge clk_fast);
    end
    check("abort_no_done", n_done, 0);
    check("abort_waits_idle", seq_busy, 1'b0);
    run_vec(vecs[0], "after_abort");

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
